// File: rtl/vu_mult_accum.sv
// Multiplier-array consumer: resolves the redundant sum/carry product over two stages,
// then optionally rounds, accumulates and saturates before writeback.
module vu_mult_accum #(
  parameter int ACC_W   = 48,
  parameter int RND_BIT = 15
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [15:0]      sumupper,
  input  logic [15:0]      carryupper,
  input  logic [15:0]      sumlower,
  input  logic [15:0]      carrylower,
  input  logic             signed_prod,
  input  logic             acc_en,
  input  logic             rnd_en,
  input  logic             acc_clear,
  input  logic             clamp_en,
  output logic             out_valid,
  output logic [15:0]      result_hi,
  output logic [15:0]      result_lo,
  output logic [ACC_W-1:0] acc_out
);

  localparam logic [ACC_W-1:0] RND_K = {{(ACC_W-1){1'b0}}, 1'b1} << RND_BIT;

  // Clamped results only when bits ACC_W-1..31 are not a pure sign extension.
  function automatic logic [31:0] sat32(input logic [ACC_W-1:0] a, input logic en);
    logic in_range;
    in_range = (&a[ACC_W-1:31]) | ~(|a[ACC_W-1:31]);
    if (!en || in_range) begin
      sat32 = a[31:0];
    end else if (a[ACC_W-1]) begin
      sat32 = 32'h8000_0000;
    end else begin
      sat32 = 32'h7FFF_FFFF;
    end
  endfunction

  logic        r_v1, r_clr1, r_sgn1, r_acc_en1, r_rnd1, r_clamp1;
  logic [15:0] r_su1, r_cu1, r_sl1, r_cl1;
  logic        r_v2, r_clr2, r_sgn2, r_acc_en2, r_rnd2, r_clamp2, r_cy2;
  logic [15:0] r_su2, r_cu2, r_lo2;
  logic [ACC_W-1:0] r_acc;
  logic        r_out_valid;
  logic [15:0] r_res_hi, r_res_lo;

  logic [16:0]      w_lo17;
  logic [15:0]      w_hi16;
  logic [31:0]      w_prod;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_acc_new;
  logic [31:0]      w_res;

  // Stage 1: operand and control capture; clear requests travel even without data.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_v1      <= 1'b0;
      r_clr1    <= 1'b0;
      r_su1     <= 16'h0000;
      r_cu1     <= 16'h0000;
      r_sl1     <= 16'h0000;
      r_cl1     <= 16'h0000;
      r_sgn1    <= 1'b0;
      r_acc_en1 <= 1'b0;
      r_rnd1    <= 1'b0;
      r_clamp1  <= 1'b0;
    end else if (!stall) begin
      r_v1   <= in_valid;
      r_clr1 <= acc_clear;
      if (in_valid) begin
        r_su1     <= sumupper;
        r_cu1     <= carryupper;
        r_sl1     <= sumlower;
        r_cl1     <= carrylower;
        r_sgn1    <= signed_prod;
        r_acc_en1 <= acc_en;
        r_rnd1    <= rnd_en;
        r_clamp1  <= clamp_en;
      end
    end
  end

  // Lower-half carry-propagate add.
  always_comb begin
    w_lo17 = {1'b0, r_sl1} + {1'b0, r_cl1};
  end

  // Stage 2: lower half resolved, carry handed to the upper half.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_v2      <= 1'b0;
      r_clr2    <= 1'b0;
      r_lo2     <= 16'h0000;
      r_cy2     <= 1'b0;
      r_su2     <= 16'h0000;
      r_cu2     <= 16'h0000;
      r_sgn2    <= 1'b0;
      r_acc_en2 <= 1'b0;
      r_rnd2    <= 1'b0;
      r_clamp2  <= 1'b0;
    end else if (!stall) begin
      r_v2   <= r_v1;
      r_clr2 <= r_clr1;
      if (r_v1) begin
        r_lo2     <= w_lo17[15:0];
        r_cy2     <= w_lo17[16];
        r_su2     <= r_su1;
        r_cu2     <= r_cu1;
        r_sgn2    <= r_sgn1;
        r_acc_en2 <= r_acc_en1;
        r_rnd2    <= r_rnd1;
        r_clamp2  <= r_clamp1;
      end
    end
  end

  // Upper resolve, extension, rounding and the next accumulator value.
  always_comb begin
    w_hi16 = r_su2 + r_cu2 + {15'd0, r_cy2};
    w_prod = {w_hi16, r_lo2};
    if (r_sgn2) begin
      w_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};
    end else begin
      w_ext = {{(ACC_W-32){1'b0}}, w_prod};
    end
    if (r_rnd2) begin
      w_ext = w_ext + RND_K;
    end else begin
      w_ext = w_ext;
    end
    if (r_clr2 || !r_acc_en2) begin
      w_base = {ACC_W{1'b0}};
    end else begin
      w_base = r_acc;
    end
    w_acc_new = w_base + w_ext;
    w_res     = sat32(w_acc_new, r_clamp2);
  end

  // Stage 3: accumulator and output registers; results hold between operations.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_acc       <= {ACC_W{1'b0}};
      r_out_valid <= 1'b0;
      r_res_hi    <= 16'h0000;
      r_res_lo    <= 16'h0000;
    end else if (!stall) begin
      r_out_valid <= r_v2;
      if (r_v2) begin
        r_acc    <= w_acc_new;
        r_res_hi <= w_res[31:16];
        r_res_lo <= w_res[15:0];
      end else if (r_clr2) begin
        r_acc <= {ACC_W{1'b0}};
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result_hi = r_res_hi;
  assign result_lo = r_res_lo;
  assign acc_out   = r_acc;

endmodule

// File: tb/tb_vu_mult_accum.sv
// Directed bench for vu_mult_accum with hand-computed expectations.
module tb_vu_mult_accum;

  logic        clk;
  logic        reset_l;
  logic        in_valid;
  logic        stall;
  logic [15:0] sumupper, carryupper, sumlower, carrylower;
  logic        signed_prod, acc_en, rnd_en, acc_clear, clamp_en;
  logic        out_valid;
  logic [15:0] result_hi, result_lo;
  logic [47:0] acc_out;

  int checks;
  int failures;

  vu_mult_accum #(.ACC_W(48), .RND_BIT(15)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .in_valid   (in_valid),
    .stall      (stall),
    .sumupper   (sumupper),
    .carryupper (carryupper),
    .sumlower   (sumlower),
    .carrylower (carrylower),
    .signed_prod(signed_prod),
    .acc_en     (acc_en),
    .rnd_en     (rnd_en),
    .acc_clear  (acc_clear),
    .clamp_en   (clamp_en),
    .out_valid  (out_valid),
    .result_hi  (result_hi),
    .result_lo  (result_lo),
    .acc_out    (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [15:0] hi,
                         input logic [15:0] lo, input logic [47:0] acc);
    chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, vld});
    chk({tag, ".hi"}, {48'd0, result_hi}, {48'd0, hi});
    chk({tag, ".lo"}, {48'd0, result_lo}, {48'd0, lo});
    chk({tag, ".acc"}, {16'd0, acc_out}, {16'd0, acc});
  endtask

  task automatic drive(input logic [31:0] sum, input logic [31:0] carry, input logic sgn,
                       input logic aen, input logic rnd, input logic clr, input logic clp);
    in_valid    = 1'b1;
    sumupper    = sum[31:16];
    sumlower    = sum[15:0];
    carryupper  = carry[31:16];
    carrylower  = carry[15:0];
    signed_prod = sgn;
    acc_en      = aen;
    rnd_en      = rnd;
    acc_clear   = clr;
    clamp_en    = clp;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    acc_clear = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_l  = 1'b0;
    stall    = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    tick();
    tick();
    chk_out("rst", 1'b0, 16'h0000, 16'h0000, 48'h0);
    reset_l = 1'b1;

    // Basic resolve with exact latency and single-cycle pulse
    drive(32'h3FFF_0001, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk("basic.lat", {63'd0, out_valid}, 64'd0);
    tick();
    chk_out("basic", 1'b1, 16'h3FFF, 16'h0001, 48'h0000_3FFF_0001);
    tick();
    chk("basic.pulse", {63'd0, out_valid}, 64'd0);

    // Carry from lower half into upper half
    drive(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    tick();
    chk_out("carry", 1'b1, 16'h0001, 16'h0000, 48'h0000_0001_0000);

    // Redundant operands in both halves: 8000+8000 carries, 1234+1111+1=2346
    drive(32'h1234_8000, 32'h1111_8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();
    chk_out("redund", 1'b1, 16'h2346, 16'h0000, 48'h0000_2346_0000);

    // Back-to-back accumulate with saturation
    drive(32'h7FFF_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(32'h7FFF_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk_out("sat1", 1'b1, 16'h7FFF, 16'h0000, 48'h0000_7FFF_0000);
    tick();
    chk_out("sat2", 1'b1, 16'h7FFF, 16'hFFFF, 48'h0000_FFFE_0000);

    // Same pair without clamping
    drive(32'h7FFF_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h7FFF_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk_out("nosat1", 1'b1, 16'h7FFF, 16'h0000, 48'h0000_7FFF_0000);
    tick();
    chk_out("nosat2", 1'b1, 16'hFFFE, 16'h0000, 48'h0000_FFFE_0000);

    // Signed, unsigned and rounded products in a row
    drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(32'h0001_8000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("neg", 1'b1, 16'hFFFF, 16'hFFFF, 48'hFFFF_FFFF_FFFF);
    idle();
    tick();
    chk_out("unsgn", 1'b1, 16'h7FFF, 16'hFFFF, 48'h0000_FFFF_FFFF);
    tick();
    chk_out("round", 1'b1, 16'h0002, 16'h0000, 48'h0000_0002_0000);

    // Clear wins over accumulate in the same operation
    drive(32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h0000_0005, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    chk_out("clrbase", 1'b1, 16'h0000, 16'h0100, 48'h0000_0000_0100);
    tick();
    chk_out("clrpri", 1'b1, 16'h0000, 16'h0005, 48'h0000_0000_0005);

    // Clear request without an operation
    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
    tick();
    tick();
    chk("clronly.acc", {16'd0, acc_out}, 64'd0);
    chk("clronly.valid", {63'd0, out_valid}, 64'd0);

    // Two-cycle stall with three operations in flight; input during stall is dropped
    drive(32'h0000_0011, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h0000_0022, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h0000_0033, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("stall.o1", 1'b1, 16'h0000, 16'h0011, 48'h11);
    stall = 1'b1;
    drive(32'hDEAD_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("stall.h1", 1'b1, 16'h0000, 16'h0011, 48'h11);
    tick();
    chk_out("stall.h2", 1'b1, 16'h0000, 16'h0011, 48'h11);
    stall = 1'b0;
    idle();
    tick();
    chk_out("stall.o2", 1'b1, 16'h0000, 16'h0022, 48'h22);
    tick();
    chk_out("stall.o3", 1'b1, 16'h0000, 16'h0033, 48'h33);
    tick();
    chk_out("stall.nojunk", 1'b0, 16'h0000, 16'h0033, 48'h33);

    // Asynchronous reset between edges with operations in flight
    drive(32'h0000_0077, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("mid.pre", {63'd0, out_valid}, 64'd1);
    #2;
    reset_l = 1'b0;
    #1;
    chk_out("mid.rst", 1'b0, 16'h0000, 16'h0000, 48'h0);
    idle();
    #2;
    reset_l = 1'b1;
    drive(32'h0000_0099, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("post.stale", {63'd0, out_valid}, 64'd0);
    tick();
    chk_out("post", 1'b1, 16'h0000, 16'h0099, 48'h99);
    tick();
    chk("post.pulse", {63'd0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vu_mult_accum.md
Name: vu_mult_accum

Overview:
- Consumer end of the vector-unit multiplier array.
- Takes the redundant sum/carry partial-product pair from one multiplier slice and resolves it with a carry-propagate add.
- Optionally rounds, then accumulates into a 48-bit per-lane accumulator.
- Returns clamped or unclamped 16-bit high and low results to the VU writeback path through a 3-stage pipeline with stall.

Parameters:
- ACC_W, 48, accumulator width in bits; must be at least 33.
- RND_BIT, 15, bit position where rounding adds 1 (that is, the round constant is 2^RND_BIT).

Ports:
- clk  input  1  VU core clock.
- reset_l  input  1  asynchronous active-low reset.
- in_valid  input  1  sum/carry operands are valid this cycle.
- stall  input  1  freezes all pipeline registers and the accumulator.
- sumupper  input  16  redundant sum, bits 31:16.
- carryupper  input  16  redundant carry, bits 31:16.
- sumlower  input  16  redundant sum, bits 15:0.
- carrylower  input  16  redundant carry, bits 15:0.
- signed_prod  input  1  sign-extend the 32-bit product (1) or zero-extend it (0).
- acc_en  input  1  add the product to the accumulator (1) or overwrite the accumulator (0).
- rnd_en  input  1  add 2^RND_BIT to the product before accumulating.
- acc_clear  input  1  clear the accumulator; honoured at stage 3.
- clamp_en  input  1  apply signed saturation to the outputs.
- out_valid  output  1  result_hi and result_lo are valid.
- result_hi  output  16  resolved or clamped bits 31:16.
- result_lo  output  16  resolved or clamped bits 15:0.
- acc_out  output  ACC_W  current accumulator value, for debug and readback.

Behaviour:
- Reset (reset_l low, asynchronous):
  - All valid flags, pipeline data registers and the accumulator go to 0.
  - out_valid=0, result_hi=0, result_lo=0, acc_out=0.
  - Reset in mid-operation discards all in-flight operations.
  - The first cycle after deassertion accepts new input.
- Stage 1 (capture):
  - When in_valid and !stall: register all four operand buses and the control bits.
  - v1 <= in_valid whenever !stall.
- Stage 2 (lower resolve):
  - lo17 = sumlower + carrylower, 17 bits.
  - Register lo17[15:0] and cy = lo17[16].
  - Pass the upper operands through.
- Stage 3 (upper resolve and accumulate):
  - hi16 = sumupper + carryupper + cy, mod 2^16; the final carry-out is discarded.
  - prod32 = {hi16, lo16}.
  - ext = prod32 sign-extended to ACC_W if signed_prod, else zero-extended.
  - If rnd_en: ext += 2^RND_BIT.
  - base = 0 if (acc_clear or !acc_en), else acc.
  - When v2 and !stall: acc <= base + ext, mod 2^ACC_W.
  - acc_clear with v2=0 and !stall clears acc to 0.
  - acc_clear and an accumulate in the same cycle: clear wins, so acc <= ext.
- Output register (loaded from the new acc value):
  - If clamp_en=0: result_hi = acc[31:16], result_lo = acc[15:0].
  - If clamp_en=1, test acc[ACC_W-1:31]:
    - All bits equal (in range): result_hi = acc[31:16], result_lo = acc[15:0].
    - Otherwise, positive (acc MSB=0): result_hi=0x7FFF, result_lo=0xFFFF.
    - Otherwise, negative (acc MSB=1): result_hi=0x8000, result_lo=0x0000.
- Latency and throughput:
  - Latency is exactly 3 unstalled cycles, in_valid to out_valid.
  - Throughput is 1 operation per cycle.
  - out_valid is a pulse per operation; there is no output backpressure.
- Stall:
  - All stage registers, acc and the outputs hold their values.
  - out_valid holds its value; the consumer must qualify it with !stall.
  - in_valid asserted while stall=1 is ignored and is not captured.
- Wrap-around:
  - The accumulator wraps modulo 2^ACC_W, with no sticky overflow.
  - Saturation is applied only at the output; the stored accumulator is never clamped.
- acc_out reflects the registered accumulator (stage-3 state).

Test Plan:
- Basic resolve: sum=0x3FFF0001, carry=0, signed_prod=1, acc_en=0, clamp_en=1 → out_valid 3 cycles later; result_hi=0x3FFF, result_lo=0x0001; acc_out=0x00003FFF0001.
- Carry across halves: sumlower=0xFFFF, carrylower=0x0001, upper operands 0 → result_hi=0x0001, result_lo=0x0000; exercises the stage-2 to stage-3 carry.
- Accumulate and saturate: two back-to-back ops, each sum=0x7FFF0000, carry=0, acc_en=1, clamp_en=1 →
  - first: result_hi=0x7FFF, result_lo=0x0000;
  - second: acc=0x0000FFFE0000, result_hi=0x7FFF, result_lo=0xFFFF;
  - repeat the second op with clamp_en=0 → result_hi=0xFFFE.
- Negative and round:
  - sum=0xFFFFFFFF, carry=0, signed_prod=1 → acc=0xFFFFFFFFFFFF, result_hi=0xFFFF, result_lo=0xFFFF;
  - same op with signed_prod=0 → acc=0x0000FFFFFFFF, clamped result_hi=0x7FFF;
  - rnd_en=1 with sum=0x00018000 → acc=0x000000020000.
- Stall and clear priority:
  - Assert stall for 2 cycles while 3 ops are in flight → outputs frozen, no op lost or duplicated, all results appear in order.
  - acc_clear together with an accumulate of 0x5 onto acc=0x100 → acc=0x5.
- Async reset mid-stream: drop reset_l between clock edges with ops in flight → out_valid=0 and acc_out=0 immediately; no stale out_valid after release.
